// File: rtl/mini_src_pkg.sv
// Shared opcode values, FSM state encoding, instruction classes and the
// control-word layout for the Mini-SRC control unit.
package mini_src_pkg;

    // 5-bit opcodes, IR[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // T-steps are consecutive so the sequencer can simply count upward
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU3, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_UNARY, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } op_class_t;

    // One bit per Datapath strobe
    typedef struct packed {
        logic PCout, Zhighout, Zlowout, LOout, HIout, MDRout, InPortout, Cout, BAout;
        logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, OutPortin, CONin;
        logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout;
    } ctrl_t;

    // Final control step of each instruction class; the boundary check keys off this
    function automatic state_t last_step(op_class_t c);
        case (c)
            C_ALU3, C_IMM, C_LDI: return S_T5;
            C_LD, C_ST:           return S_T7;
            C_MULDIV, C_BR:       return S_T6;
            C_UNARY, C_JAL:       return S_T4;
            C_NOP, C_HALT:        return S_T2;
            default:              return S_T3;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> Datapath bundle: IR/CON/Stop feed the sequencer, strobes drive the Datapath.
interface control_unit_if;
    logic [31:0] IR;
    logic        CON;
    logic        Stop;
    logic        Run;
    logic PCout, Zhighout, Zlowout, LOout, HIout, MDRout, InPortout, Cout, BAout;
    logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, OutPortin, CONin;
    logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout;

    modport master (
        input  IR, CON, Stop,
        output Run,
        output PCout, Zhighout, Zlowout, LOout, HIout, MDRout, InPortout, Cout, BAout,
        output MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, OutPortin, CONin,
        output IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout
    );

    modport slave (
        output IR, CON, Stop,
        input  Run,
        input  PCout, Zhighout, Zlowout, LOout, HIout, MDRout, InPortout, Cout, BAout,
        input  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, OutPortin, CONin,
        input  IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout
    );
endinterface

// File: rtl/control_unit_opcode_class_decode.sv
// Opcode -> instruction class; undefined opcodes behave as nop.
module opcode_class_decode
    import mini_src_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  cls
);

    // Pure table lookup
    always_comb begin
        cls = C_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:     cls = C_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:            cls = C_IMM;
            OP_LDI:                              cls = C_LDI;
            OP_LD:                               cls = C_LD;
            OP_ST:                               cls = C_ST;
            OP_MUL, OP_DIV:                      cls = C_MULDIV;
            OP_NEG, OP_NOT:                      cls = C_UNARY;
            OP_BR:                               cls = C_BR;
            OP_JR:                               cls = C_JR;
            OP_JAL:                              cls = C_JAL;
            OP_IN:                               cls = C_IN;
            OP_OUT:                              cls = C_OUT;
            OP_MFHI:                             cls = C_MFHI;
            OP_MFLO:                             cls = C_MFLO;
            OP_HALT:                             cls = C_HALT;
            default:                             cls = C_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Mini-SRC sequencer: fetch/decode/execute FSM, one control step per clock,
// Moore-decoded strobes from the state plus the class latched at the end of T2.
module control_unit
    import mini_src_pkg::*;
#(
    parameter bit RUN_ON_RESET = 1'b1
) (
    input  logic           clock,
    input  logic           clear,
    control_unit_if.master bus
);

    state_t    state_q, state_d;
    op_class_t dec_cls, cls_q;
    ctrl_t     ctl;
    logic      stop_pend;
    logic      stop_req;
    logic      at_boundary;

    // Only the opcode field steers sequencing; register fields are consumed by the Datapath
    logic unused_ir;
    assign unused_ir = ^bus.IR[26:0];

    opcode_class_decode u_dec (
        .opcode (bus.IR[31:27]),
        .cls    (dec_cls)
    );

    // A Stop seen at any point of an instruction is held until the instruction ends
    assign stop_req    = bus.Stop | stop_pend;
    assign at_boundary = (state_d == S_T0) || (state_d == S_HALT);

    // State register, latched instruction class and pending-stop flag
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= S_RESET;
            cls_q     <= C_NOP;
            stop_pend <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (state_q == S_T2)
                cls_q <= dec_cls;
            stop_pend <= at_boundary ? 1'b0 : (stop_pend | bus.Stop);
        end
    end

    // Next-state: fixed fetch, decode at T2, count up to the class's last step
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = RUN_ON_RESET ? S_T0 : S_HALT;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2: begin
                if (dec_cls == C_HALT)
                    state_d = S_HALT;
                else if (dec_cls == C_NOP)
                    state_d = stop_req ? S_HALT : S_T0;
                else
                    state_d = S_T3;
            end
            S_HALT: begin
                if (!RUN_ON_RESET && !bus.Stop)
                    state_d = S_T0;
            end
            default: begin
                if (state_q == last_step(cls_q))
                    state_d = stop_req ? S_HALT : S_T0;
                else
                    state_d = state_t'(state_q + 4'd1);
            end
        endcase
    end

    // Strobe decode: every strobe defaults low, each step raises only its own set
    always_comb begin
        ctl = '0;
        case (state_q)
            S_T0: begin ctl.PCout = 1'b1; ctl.MARin = 1'b1; ctl.IncPC = 1'b1; ctl.Zlowin = 1'b1; end
            S_T1: begin ctl.Zlowout = 1'b1; ctl.PCin = 1'b1; ctl.Read = 1'b1; ctl.MDRin = 1'b1; end
            S_T2: begin ctl.MDRout = 1'b1; ctl.IRin = 1'b1; end
            S_T3: begin
                case (cls_q)
                    C_ALU3, C_IMM: begin ctl.Grb = 1'b1; ctl.Rout = 1'b1; ctl.Yin = 1'b1; end
                    C_LDI, C_LD, C_ST: begin ctl.Grb = 1'b1; ctl.BAout = 1'b1; ctl.Yin = 1'b1; end
                    C_MULDIV: begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.Yin = 1'b1; end
                    C_UNARY:  begin ctl.Grb = 1'b1; ctl.Rout = 1'b1; ctl.Zlowin = 1'b1; end
                    C_BR:     begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.CONin = 1'b1; end
                    C_JR:     begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.PCin = 1'b1; end
                    C_JAL:    begin ctl.PCout = 1'b1; ctl.Grb = 1'b1; ctl.Rin = 1'b1; end
                    C_IN:     begin ctl.InPortout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
                    C_OUT:    begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.OutPortin = 1'b1; end
                    C_MFHI:   begin ctl.HIout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
                    C_MFLO:   begin ctl.LOout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls_q)
                    C_ALU3: begin ctl.Grc = 1'b1; ctl.Rout = 1'b1; ctl.Zlowin = 1'b1; end
                    C_IMM, C_LDI, C_LD, C_ST: begin ctl.Cout = 1'b1; ctl.Zlowin = 1'b1; end
                    C_MULDIV: begin
                        ctl.Grb = 1'b1; ctl.Rout = 1'b1; ctl.Zhighin = 1'b1; ctl.Zlowin = 1'b1;
                    end
                    C_UNARY: begin ctl.Zlowout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
                    C_BR:    begin ctl.PCout = 1'b1; ctl.Yin = 1'b1; end
                    C_JAL:   begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.PCin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls_q)
                    C_ALU3, C_IMM, C_LDI: begin ctl.Zlowout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
                    C_LD, C_ST: begin ctl.Zlowout = 1'b1; ctl.MARin = 1'b1; end
                    C_MULDIV:   begin ctl.Zlowout = 1'b1; ctl.LOin = 1'b1; end
                    C_BR:       begin ctl.Cout = 1'b1; ctl.Zlowin = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls_q)
                    C_LD:     begin ctl.Read = 1'b1; ctl.MDRin = 1'b1; end
                    C_ST:     begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.MDRin = 1'b1; end
                    C_MULDIV: begin ctl.Zhighout = 1'b1; ctl.HIin = 1'b1; end
                    // CON was loaded by CONin in T3 and is stable by now
                    C_BR:     begin ctl.Zlowout = 1'b1; ctl.PCin = bus.CON; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls_q)
                    C_LD: begin ctl.MDRout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
                    C_ST: ctl.Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.Run = (state_q != S_RESET) && (state_q != S_HALT);

    assign bus.PCout     = ctl.PCout;     assign bus.Zhighout  = ctl.Zhighout;
    assign bus.Zlowout   = ctl.Zlowout;   assign bus.LOout     = ctl.LOout;
    assign bus.HIout     = ctl.HIout;     assign bus.MDRout    = ctl.MDRout;
    assign bus.InPortout = ctl.InPortout; assign bus.Cout      = ctl.Cout;
    assign bus.BAout     = ctl.BAout;     assign bus.MARin     = ctl.MARin;
    assign bus.PCin      = ctl.PCin;      assign bus.MDRin     = ctl.MDRin;
    assign bus.IRin      = ctl.IRin;      assign bus.Yin       = ctl.Yin;
    assign bus.HIin      = ctl.HIin;      assign bus.LOin      = ctl.LOin;
    assign bus.Zhighin   = ctl.Zhighin;   assign bus.Zlowin    = ctl.Zlowin;
    assign bus.OutPortin = ctl.OutPortin; assign bus.CONin     = ctl.CONin;
    assign bus.IncPC     = ctl.IncPC;     assign bus.Read      = ctl.Read;
    assign bus.Write     = ctl.Write;     assign bus.Gra       = ctl.Gra;
    assign bus.Grb       = ctl.Grb;       assign bus.Grc       = ctl.Grc;
    assign bus.Rin       = ctl.Rin;       assign bus.Rout      = ctl.Rout;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic clock = 1'b0;
  logic clear = 1'b1;
  control_unit_if bus();

  control_unit #(.RUN_ON_RESET(1'b1)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  string NAMES [28] = '{"PCout", "Zhighout", "Zlowout", "LOout", "HIout", "MDRout",
                        "InPortout", "Cout", "BAout", "MARin", "PCin", "MDRin", "IRin",
                        "Yin", "HIin", "LOin", "Zhighin", "Zlowin", "OutPortin", "CONin",
                        "IncPC", "Read", "Write", "Gra", "Grb", "Grc", "Rin", "Rout"};

  logic [27:0] act;
  assign act = {bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra, bus.Write, bus.Read, bus.IncPC,
                bus.CONin, bus.OutPortin, bus.Zlowin, bus.Zhighin, bus.LOin, bus.HIin,
                bus.Yin, bus.IRin, bus.MDRin, bus.PCin, bus.MARin, bus.BAout, bus.Cout,
                bus.InPortout, bus.MDRout, bus.HIout, bus.LOout, bus.Zlowout, bus.Zhighout,
                bus.PCout};

  logic [28:0] exp_q[$];
  string       tag_q[$];
  logic [27:0] prog_q[$];

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [28:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if ({bus.Run, act} !== e) begin
        errors++;
        $display("FAIL %s: got Run=%b strobes=%h, want Run=%b strobes=%h",
                 t, bus.Run, act, e[28], e[27:0]);
      end
    end
  end

  initial begin
    #5000000;
    errors++;
    $display("FAIL timeout: wait expired with %0d expected words pending", exp_q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic int bit_of(string n);
    for (int i = 0; i < 28; i++)
      if (NAMES[i] == n) return i;
    return -1;
  endfunction

  function automatic string micro(logic [4:0] op);
    case (op)
      5'd0:  return "Grb BAout Yin|Cout Zlowin|Zlowout MARin|Read MDRin|MDRout Gra Rin";
      5'd1:  return "Grb BAout Yin|Cout Zlowin|Zlowout Gra Rin";
      5'd2:  return "Grb BAout Yin|Cout Zlowin|Zlowout MARin|Gra Rout MDRin|Write";
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11:
             return "Grb Rout Yin|Grc Rout Zlowin|Zlowout Gra Rin";
      5'd12, 5'd13, 5'd14:
             return "Grb Rout Yin|Cout Zlowin|Zlowout Gra Rin";
      5'd15, 5'd16:
             return "Gra Rout Yin|Grb Rout Zhighin Zlowin|Zlowout LOin|Zhighout HIin";
      5'd17, 5'd18: return "Grb Rout Zlowin|Zlowout Gra Rin";
      5'd19: return "Gra Rout CONin|PCout Yin|Cout Zlowin|Zlowout PCin?";
      5'd20: return "Gra Rout PCin";
      5'd21: return "PCout Grb Rin|Gra Rout PCin";
      5'd22: return "InPortout Gra Rin";
      5'd23: return "Gra Rout OutPortin";
      5'd24: return "HIout Gra Rin";
      5'd25: return "LOout Gra Rin";
      default: return "";
    endcase
  endfunction

  task automatic build(input logic [31:0] ir, input bit con);
    string s, tok, ch, m;
    logic [27:0] v;
    int b;
    s = "PCout MARin IncPC Zlowin|Zlowout PCin Read MDRin|MDRout IRin";
    m = micro(ir[31:27]);
    if (m != "") s = {s, "|", m};
    s = {s, "|"};
    prog_q.delete();
    v = '0;
    tok = "";
    for (int i = 0; i < s.len(); i++) begin
      ch = s.substr(i, i);
      if (ch == " " || ch == "|") begin
        if (tok == "PCin?") begin
          b = bit_of("PCin");
          if (con && b >= 0) v[b] = 1'b1;
        end else if (tok != "") begin
          b = bit_of(tok);
          if (b >= 0) v[b] = 1'b1;
        end
        tok = "";
        if (ch == "|") begin
          prog_q.push_back(v);
          v = '0;
        end
      end else begin
        tok = {tok, ch};
      end
    end
  endtask

  task automatic push(input logic run, input logic [27:0] v, input string t);
    exp_q.push_back({run, v});
    tag_q.push_back(t);
  endtask

  task automatic do_reset();
    clear = 1'b1;
    #1;
    checks++;
    if (bus.Run !== 1'b0 || act !== '0) begin
      errors++;
      $display("FAIL reset state: got Run=%b strobes=%h, want Run=0 strobes=0", bus.Run, act);
    end
    push(1'b0, '0, "reset held");
    @(posedge clock); #1;
    clear = 1'b0;
    push(1'b0, '0, "reset released");
    @(posedge clock); #1;
  endtask

  task automatic run_instr(input logic [31:0] ir, input bit con, input int stop_at);
    bus.IR  = ir;
    bus.CON = con;
    build(ir, con);
    for (int k = 0; k < prog_q.size(); k++)
      push(1'b1, prog_q[k], $sformatf("ir=%h con=%0d T%0d", ir, con, k));
    for (int k = 0; k < prog_q.size(); k++) begin
      if (k == stop_at) bus.Stop = 1'b1;
      @(posedge clock); #1;
    end
  endtask

  task automatic halt_cycles(input int n, input string t);
    for (int k = 0; k < n; k++) push(1'b0, '0, t);
    repeat (n) @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] r;
    logic [4:0]  op;
    bus.IR   = '0;
    bus.CON  = 1'b0;
    bus.Stop = 1'b0;
    @(posedge clock); #1;
    do_reset();

    run_instr(32'h1A920000, 1'b0, -1);
    run_instr(32'h00000000, 1'b0, -1);
    run_instr(32'h98000000, 1'b1, -1);
    run_instr(32'h98000000, 1'b0, -1);
    run_instr(32'hD0000000, 1'b0, -1);

    bus.IR = 32'h1A920000;
    build(32'h1A920000, 1'b0);
    for (int k = 0; k < 5; k++) push(1'b1, prog_q[k], $sformatf("pre-clear T%0d", k));
    repeat (4) @(posedge clock);
    @(negedge clock); #2;
    clear = 1'b1;
    @(posedge clock); #1;
    push(1'b0, '0, "clear mid-T4");
    clear = 1'b0;
    @(posedge clock); #1;
    run_instr(32'h1A920000, 1'b0, -1);

    run_instr(32'h1A920000, 1'b0, 4);
    halt_cycles(5, "halt via Stop");
    bus.Stop = 1'b0;
    halt_cycles(3, "halt after Stop drop");
    do_reset();

    bus.IR = 32'hD8000000;
    build(32'hD8000000, 1'b0);
    for (int k = 0; k < 3; k++) push(1'b1, prog_q[k], $sformatf("halt fetch T%0d", k));
    repeat (3) @(posedge clock); #1;
    halt_cycles(100, "halt instr");
    do_reset();
    run_instr(32'h0A120000, 1'b0, -1);

    for (int n = 0; n < 150; n++) begin
      r  = $urandom;
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      run_instr({op, r[26:0]}, 1'($urandom_range(0, 1)), -1);
    end

    @(negedge clock); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expected words never sampled", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
